// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling feeding a
// first-word-fall-through byte FIFO on a valid/ready stream.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          clr_err,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [PW-1:0] P_ONE   = PW'(1);
  localparam logic [PW:0]   N_ONE   = (PW+1)'(1);
  localparam logic [PW:0]   N_FULL  = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          rx_meta_q;
  logic          rx_s_q;
  logic          rx_prev_q;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          frame_err_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic [PW:0]   count_d;
  logic          overrun_q;
  logic          overrun_d;

  logic          push;
  logic          pop;
  logic          full;
  logic          wr_en;

  // Two-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Frame FSM: start qualify, data shift, stop check, break hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q && rx_prev_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end
        S_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            idx_q <= '0;
            state_q <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + C_ONE;
          end
        end
        S_DATA: begin
          if (cnt_q == LAST) begin
            shift_q[idx_q] <= rx_s_q;
            cnt_q <= '0;
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + C_ONE;
          end
        end
        S_STOP: begin
          if (cnt_q == LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + C_ONE;
          end
        end
        S_BREAK: begin
          if (rx_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign push  = (state_q == S_STOP) && (cnt_q == LAST) && rx_s_q;
  assign full  = (count_q == N_FULL);
  assign pop   = (count_q != '0) && m_ready;
  assign wr_en = push && (!full || pop);

  // Occupancy and sticky overrun; a set beats a same-cycle clear.
  always_comb begin
    count_d   = count_q;
    overrun_d = overrun_q;
    if (wr_en && !pop)      count_d = count_q + N_ONE;
    else if (!wr_en && pop) count_d = count_q - N_ONE;
    if (push && full && !pop) overrun_d = 1'b1;
    else if (clr_err)         overrun_d = 1'b0;
  end

  // FIFO pointers and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + P_ONE;
      if (pop)   rd_ptr_q <= rd_ptr_q + P_ONE;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Byte storage; contents only matter behind a valid count.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= shift_q;
  end

  assign m_valid    = (count_q != '0);
  assign m_data     = m_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: frames driven on rx,
// expected bytes queued, compared as the stream pops them.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int BIT = 320;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       frame_err;
  logic       overrun;
  logic       clr_err;
  logic       busy;
  logic [2:0] fifo_count;

  int         n_chk;
  int         n_err;
  int         fe_cnt;
  int         fe0;
  int         n;
  int         push_lat;
  logic [7:0] sb [$];

  uart_rx_fifo #(
    .CLKS_PER_BIT(32),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .frame_err(frame_err),
    .overrun(overrun),
    .clr_err(clr_err),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic stop);
    rx = 1'b0;
    #(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(BIT);
    end
    rx = stop;
    #(BIT);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic tick(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  // Pop the scoreboard on each accepted stream beat.
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (!rst && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_pop_sb", sb.size(), 1);
      end else begin
        chk("m_data", {24'h0, m_data},
            {24'h0, sb.pop_front()});
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk   = 0;
    n_err   = 0;
    fe_cnt  = 0;
    rst     = 1'b1;
    rx      = 1'b1;
    m_ready = 1'b1;
    clr_err = 1'b0;
    tick(3);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fifo_count", fifo_count, 0);
    rst = 1'b0;
    tick(5);

    // Single byte, latency and one-cycle valid.
    fe0 = fe_cnt;
    sb.push_back(8'hA5);
    fork
      send_byte(8'hA5, 1'b1);
    join_none
    n = 0;
    while (n < 400 && !m_valid) begin
      @(posedge clk);
      #1;
      n++;
    end
    push_lat = n;
    chk("a5_latency_in_304_308",
        (n >= 304 && n <= 308), 1);
    tick(1);
    chk("a5_valid_one_cycle", m_valid, 0);
    #400;
    tick(1);
    chk("a5_frame_err", fe_cnt - fe0, 0);
    chk("a5_overrun", overrun, 0);
    drain("a5_drain");

    // Overrun with consumer stalled.
    m_ready = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      if (b <= 4) sb.push_back(8'(b));
      send_byte(8'(b), 1'b1);
    end
    tick(2);
    chk("ovr_fifo_count", fifo_count, 4);
    chk("ovr_overrun", overrun, 1);
    m_ready = 1'b1;
    drain("ovr_drain");
    tick(1);
    chk("ovr_empty_valid", m_valid, 0);
    chk("ovr_empty_count", fifo_count, 0);
    chk("ovr_sticky", overrun, 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    chk("clr_err_overrun", overrun, 0);

    // Short glitch must not start a frame.
    fe0 = fe_cnt;
    rx = 1'b0;
    #100;
    rx = 1'b1;
    tick(20);
    chk("glitch_busy", busy, 0);
    chk("glitch_frame_err", fe_cnt - fe0, 0);
    chk("glitch_count", fifo_count, 0);
    sb.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    drain("glitch_3c_drain");

    // Bad stop bit then a held-low line.
    tick(1);
    fe0 = fe_cnt;
    send_byte(8'hFF, 1'b0);
    #1000;
    chk("brk_frame_err_pulses", fe_cnt - fe0, 1);
    chk("brk_busy", busy, 1);
    chk("brk_count", fifo_count, 0);
    rx = 1'b1;
    tick(10);
    chk("brk_busy_release", busy, 0);
    sb.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    drain("brk_7e_drain");

    // Full FIFO with a pop exactly on the push cycle.
    m_ready = 1'b0;
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    sb.push_back(8'h33);
    sb.push_back(8'h44);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    tick(1);
    chk("full_count", fifo_count, 4);
    sb.push_back(8'h99);
    fork
      send_byte(8'h99, 1'b1);
    join_none
    tick(push_lat - 1);
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    chk("simul_overrun", overrun, 0);
    chk("simul_count", fifo_count, 4);
    #500;
    tick(1);
    chk("simul_overrun_late", overrun, 0);
    m_ready = 1'b1;
    drain("simul_drain");

    // Reset in the middle of data bit 3.
    tick(2);
    rx = 1'b0;
    #(BIT);
    for (int i = 0; i < 3; i++) begin
      rx = (i % 2 == 0) ? 1'b1 : 1'b0;
      #(BIT);
    end
    rx = 1'b0;
    #(BIT / 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_data", m_data, 0);
    tick(5);
    rx = 1'b1;
    rst = 1'b0;
    tick(400);
    chk("post_rst_no_push", fifo_count, 0);
    chk("post_rst_busy", busy, 0);
    sb.push_back(8'hC3);
    send_byte(8'hC3, 1'b1);
    drain("c3_drain");
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
